// File: rtl/fetch_axil_master.sv
// Instruction-fetch stage: owns the PC, issues one AXI4-Lite read per instruction and
// buffers returned words with their PC in a 2-entry FIFO toward decode.

`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

module fetch_axil_master #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = `PC_RESET,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,

    output logic [ADDR_WIDTH-1:0] o_axil_araddr,
    output logic                  o_axil_arvalid,
    input  logic                  i_axil_arready,
    input  logic [DATA_WIDTH-1:0] i_axil_rdata,
    input  logic                  i_axil_rvalid,
    output logic                  o_axil_rready,

    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam logic [1:0] FIFO_FULL = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  discard_q;

    logic [1:0]            count_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [ADDR_WIDTH-1:0] fifo_pc_q   [2];
    logic [DATA_WIDTH-1:0] fifo_data_q [2];

    logic                  ar_hs;
    logic                  r_hs;
    logic                  push;
    logic                  pop;

    assign ar_hs = (state_q == S_AR) && arvalid_q && i_axil_arready;
    assign r_hs  = (state_q == S_R) && rready_q && i_axil_rvalid;
    // A beat that races a redirect belongs to the old stream and is dropped.
    assign push  = r_hs && !discard_q && !i_redirect;
    assign pop   = i_ready && (count_q != 2'd0);

    // A handshake for a request already made stale by a redirect must not advance
    // the new PC, otherwise the first target word would be skipped.
    always_comb begin
        // NOTE: default first so every path assigns pc_d and no latch is inferred.
        pc_d = pc_q;
        if (i_redirect) begin
            pc_d = i_redirect_pc;
        end else if (ar_hs && !discard_q) begin
            pc_d = pc_q + ADDR_WIDTH'(4);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            unique case (state_q)
                S_IDLE: begin
                    if (!i_redirect && (count_q < FIFO_FULL)) begin
                        araddr_q  <= pc_q;
                        req_pc_q  <= pc_q;
                        arvalid_q <= 1'b1;
                        rready_q  <= 1'b1;
                        state_q   <= S_AR;
                    end
                end
                S_AR: begin
                    // An issued AR cannot be withdrawn; mark its data as stale instead.
                    if (i_redirect) begin
                        discard_q <= 1'b1;
                    end
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (r_hs) begin
                        rready_q  <= 1'b0;
                        discard_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (i_redirect) begin
                        discard_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            // NOTE: storage is reset on purpose: o_instr/o_pc read straight from it and
            // must be zero out of reset.
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else if (i_redirect) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_pc_q[wr_ptr_q]   <= req_pc_q;
                fifo_data_q[wr_ptr_q] <= i_axil_rdata;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_axil_araddr  = araddr_q;
    assign o_axil_arvalid = arvalid_q;
    assign o_axil_rready  = rready_q;

    assign o_instr = fifo_data_q[rd_ptr_q];
    assign o_pc    = fifo_pc_q[rd_ptr_q];
    assign o_valid = (count_q != 2'd0);

endmodule

// File: tb/tb_fetch_axil_master.sv
// Bench for fetch_axil_master: AXI-Lite ROM slave with programmable AR wait, decode-side
// stream model (sequential PCs since last reset/redirect) and directed scenarios.

module tb_fetch_axil_master;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic [31:0] o_axil_araddr;
    logic        o_axil_arvalid;
    logic        i_axil_arready = 1'b0;
    logic [31:0] i_axil_rdata = 32'h0;
    logic        i_axil_rvalid = 1'b0;
    logic        o_axil_rready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        i_ready = 1'b0;

    fetch_axil_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_axil_araddr (o_axil_araddr),
        .o_axil_arvalid(o_axil_arvalid),
        .i_axil_arready(i_axil_arready),
        .i_axil_rdata  (i_axil_rdata),
        .i_axil_rvalid (i_axil_rvalid),
        .o_axil_rready (o_axil_rready),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Slave / model state, owned by the negedge process below.
    int          cyc = 0;
    int          ar_delay = 0;
    int          ar_wait = 0;
    logic        ar_go = 1'b0;
    logic        r_busy = 1'b0;
    logic [31:0] r_addr = 32'h0;
    logic [31:0] exp_pc = RESET_PC;
    logic        flush_chk = 1'b0;
    logic        prev_ok = 1'b0;
    logic        prev_arvalid, prev_arready, prev_rvalid, prev_rready;
    logic [31:0] prev_araddr;

    logic [31:0] ar_log[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_instr[$];
    int          cons_cyc[$];

    // Sampling and slave drive happen on the falling edge; the DUT acts on the rising edge.
    always @(negedge clk) begin
        if (!resetn) begin
            cyc = 0; exp_pc = RESET_PC; prev_ok = 1'b0; r_busy = 1'b0; ar_wait = 0;
            ar_go = 1'b0; flush_chk = 1'b0;
            i_axil_arready = 1'b0; i_axil_rvalid = 1'b0; i_axil_rdata = 32'h0;
        end else begin
            cyc++;
            if (prev_ok && prev_rvalid && prev_rready) r_busy = 1'b0;
            if (prev_ok && prev_arvalid && prev_arready) begin
                ar_log.push_back(prev_araddr);
                r_busy = 1'b1;
                r_addr = prev_araddr;
            end
            if (prev_ok && prev_arvalid && !prev_arready) begin
                check("ar_hold_valid", 32'(o_axil_arvalid), 32'd1);
                check("ar_hold_addr", o_axil_araddr, prev_araddr);
            end
            if (r_busy) begin
                check("one_outstanding", 32'(o_axil_arvalid), 32'd0);
                check("rready_in_r", 32'(o_axil_rready), 32'd1);
            end
            if (flush_chk) check("flush_empty", 32'(o_valid), 32'd0);
            flush_chk = 1'b0;
            if (i_redirect) begin
                exp_pc    = i_redirect_pc;
                flush_chk = 1'b1;
            end else if (o_valid && i_ready) begin
                check("stream_pc", o_pc, exp_pc);
                check("stream_instr", o_instr, rom(exp_pc));
                cons_pc.push_back(o_pc);
                cons_instr.push_back(o_instr);
                cons_cyc.push_back(cyc);
                exp_pc = exp_pc + 32'd4;
            end
            i_axil_rvalid = r_busy;
            i_axil_rdata  = r_busy ? rom(r_addr) : 32'h0;
            if (o_axil_arvalid && !r_busy) begin
                i_axil_arready = (ar_wait >= ar_delay);
                ar_wait        = i_axil_arready ? 0 : ar_wait + 1;
            end else begin
                i_axil_arready = 1'b0;
            end
            ar_go        = o_axil_arvalid && i_axil_arready;
            prev_arvalid = o_axil_arvalid;
            prev_araddr  = o_axil_araddr;
            prev_arready = i_axil_arready;
            prev_rvalid  = i_axil_rvalid;
            prev_rready  = o_axil_rready;
            prev_ok      = 1'b1;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arvalid"}, 32'(o_axil_arvalid), 32'd0);
        check({tag, "_rready"}, 32'(o_axil_rready), 32'd0);
        check({tag, "_araddr"}, o_axil_araddr, 32'h0);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_instr"}, o_instr, 32'h0);
        check({tag, "_pc"}, o_pc, 32'h0);
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        i_redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        ar_log.delete();
        cons_pc.delete();
        cons_instr.delete();
        cons_cyc.delete();
        resetn = 1'b1;
    endtask

    task automatic wait_cons(input int n, input int budget);
        int i = 0;
        while (cons_pc.size() < n && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("wait_cons", 32'(cons_pc.size() >= n), 32'd1);
    endtask

    task automatic redirect_once(input logic [31:0] target);
        i_redirect_pc = target;
        i_redirect    = 1'b1;
        @(posedge clk);
        #1;
        i_redirect = 1'b0;
    endtask

    int          hi;
    int          n0;
    int          n_ar;
    logic [31:0] a_old;

    initial begin
        #1 resetn = 1'b0;

        // 1: free-running fetch, zero-wait slave.
        i_ready = 1'b1; ar_delay = 0;
        do_reset();
        wait_cons(3, 40);
        check("t1_pc0", cons_pc[0], 32'h0);
        check("t1_pc1", cons_pc[1], 32'h4);
        check("t1_pc2", cons_pc[2], 32'h8);
        check("t1_instr1", cons_instr[1], 32'hDEAD_BEEB);
        check("t1_first_valid_cycle", 32'(cons_cyc[0]), 32'd4);
        check("t1_cadence_a", 32'(cons_cyc[1] - cons_cyc[0]), 32'd3);
        check("t1_cadence_b", 32'(cons_cyc[2] - cons_cyc[1]), 32'd3);

        // 2: decode stalled -> exactly two fetches, then resume.
        i_ready = 1'b0;
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        check("t2_ar_count", 32'(ar_log.size()), 32'd2);
        check("t2_ar0", ar_log[0], 32'h0);
        check("t2_ar1", ar_log[1], 32'h4);
        check("t2_valid", 32'(o_valid), 32'd1);
        check("t2_head_pc", o_pc, 32'h0);
        check("t2_head_instr", o_instr, 32'hDEAD_BEEF);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (o_axil_arvalid) hi++;
        end
        check("t2_no_issue_when_full", 32'(hi), 32'd0);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        wait_cons(3, 40);
        check("t2_pc2", cons_pc[2], 32'h8);
        check("t2_ar2", ar_log[2], 32'h8);

        // 3: slave holds arready low for 5 cycles per request.
        ar_delay = 5;
        do_reset();
        wait_cons(3, 80);
        check("t3_first_valid_cycle", 32'(cons_cyc[0]), 32'd9);
        check("t3_cadence", 32'(cons_cyc[1] - cons_cyc[0]), 32'd8);
        check("t3_ar0", ar_log[0], 32'h0);
        check("t3_ar1", ar_log[1], 32'h4);
        check("t3_ar2", ar_log[2], 32'h8);

        // 4: redirect in R, coinciding with the R handshake.
        ar_delay = 0;
        do_reset();
        wait_cons(2, 40);
        hi = 0;
        while (!ar_go && hi < 20) begin
            @(posedge clk);
            #1;
            hi++;
        end
        check("t4_found_ar_hs", 32'(ar_go), 32'd1);
        n0 = cons_pc.size();
        i_redirect_pc = 32'h100;
        i_redirect    = 1'b1;
        @(negedge clk);
        #1;
        check("t4_r_pending", 32'({o_axil_rready, i_axil_rvalid}), 32'd3);
        @(posedge clk);
        #1;
        i_redirect = 1'b0;
        wait_cons(n0 + 2, 40);
        check("t4_ar_dropped", ar_log[2], 32'h8);
        check("t4_pc_a", cons_pc[n0], 32'h100);
        check("t4_pc_b", cons_pc[n0 + 1], 32'h104);

        // 5: redirect while AR is still waiting for arready.
        ar_delay = 3;
        do_reset();
        wait_cons(1, 40);
        hi = 0;
        while (!o_axil_arvalid && hi < 20) begin
            @(posedge clk);
            #1;
            hi++;
        end
        a_old = o_axil_araddr;
        n_ar  = ar_log.size();
        n0    = cons_pc.size();
        check("t5_old_addr", a_old, 32'h4);
        redirect_once(32'h200);
        wait_cons(n0 + 2, 80);
        check("t5_old_ar_completes", ar_log[n_ar], 32'h4);
        check("t5_next_ar", ar_log[n_ar + 1], 32'h200);
        check("t5_following_ar", ar_log[n_ar + 2], 32'h204);
        check("t5_pc_a", cons_pc[n0], 32'h200);
        check("t5_pc_b", cons_pc[n0 + 1], 32'h204);

        // 6: asynchronous reset mid-AR with an entry buffered.
        ar_delay = 4; i_ready = 1'b0;
        do_reset();
        hi = 0;
        while (!(o_valid && o_axil_arvalid) && hi < 40) begin
            @(posedge clk);
            #1;
            hi++;
        end
        check("t6_mid_ar", 32'(o_valid && o_axil_arvalid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        ar_delay = 0; i_ready = 1'b1;
        do_reset();
        wait_cons(1, 40);
        check("t6_refetch_ar", ar_log[0], RESET_PC);
        check("t6_refetch_pc", cons_pc[0], RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
